// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RISC-V MEM stage: data memory access FSM and MEM/WB register
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic [2:0]  funct3_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_req,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        misalign_out,
  output logic        bus_error_out
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_nx;
  logic [TO_W-1:0] count;
  logic [31:0]     load_data;
  logic            err_pend;

  logic        mem_op, is_load, misalign, timeout_hit;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx, load_fmt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign mem_op      = mem_read_in | mem_write_in;
  assign is_load     = mem_read_in & ~mem_write_in;
  assign timeout_hit = (TIMEOUT != 0) && (count == TO_W'(TIMEOUT - 1));

  // Size decode uses funct3[1:0]; reserved encodings fall into the word case.
  always_comb begin
    misalign = 1'b0;
    be_nx    = 4'hF;
    wdata_nx = write_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        be_nx    = 4'b0001 << alu_result_in[1:0];
        wdata_nx = {4{write_data_in[7:0]}};
      end
      2'b01: begin
        misalign = alu_result_in[0];
        be_nx    = 4'b0011 << {alu_result_in[1], 1'b0};
        wdata_nx = {2{write_data_in[15:0]}};
      end
      default: misalign = (alu_result_in[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    case (alu_result_in[1:0])
      2'b00:   lane_b = dmem_rdata[7:0];
      2'b01:   lane_b = dmem_rdata[15:8];
      2'b10:   lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_in[1:0])
      2'b00:   load_fmt = {{24{~funct3_in[2] & lane_b[7]}}, lane_b};
      2'b01:   load_fmt = {{16{~funct3_in[2] & lane_h[15]}}, lane_h};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nx  = state;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misalign) begin
          stall_req = 1'b1;
          state_nx  = REQ;
        end
      end
      REQ: begin
        stall_req = 1'b1;
        if (dmem_ready || timeout_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      load_data      <= '0;
      err_pend       <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      misalign_out   <= 1'b0;
      bus_error_out  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          count <= '0;
          if (mem_op && !misalign) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= {alu_result_in[31:2], 2'b00};
            dmem_wdata <= wdata_nx;
            dmem_be    <= be_nx;
            err_pend   <= 1'b0;
            load_data  <= '0;
          end
        end
        REQ: begin
          count <= count + 1'b1;
          if (dmem_ready) begin
            dmem_req  <= 1'b0;
            load_data <= is_load ? load_fmt : 32'h0;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            err_pend <= 1'b1;
          end
        end
        default: count <= '0;
      endcase

      // A stalled instruction reaches MEM/WB only once, in its DONE cycle.
      if (stall_req) begin
        alu_result_out <= '0;
        mem_data_out   <= '0;
        rd_out         <= '0;
        reg_write_out  <= 1'b0;
        mem_to_reg_out <= 1'b0;
        misalign_out   <= 1'b0;
        bus_error_out  <= 1'b0;
      end else begin
        alu_result_out <= alu_result_in;
        rd_out         <= rd_in;
        mem_to_reg_out <= mem_to_reg_in;
        if (state == DONE) begin
          mem_data_out  <= load_data;
          reg_write_out <= reg_write_in & ~err_pend;
          misalign_out  <= 1'b0;
          bus_error_out <= err_pend;
        end else begin
          mem_data_out  <= '0;
          reg_write_out <= reg_write_in & ~mem_op;
          misalign_out  <= mem_op;
          bus_error_out <= 1'b0;
        end
      end
    end
  end

endmodule
